// File: rtl/paint_pkg.sv
// paint_pkg: shared brush/state types and grid geometry for the paint controller
package paint_pkg;
  localparam int GRID_W      = 64;
  localparam int GRID_H      = 60;
  localparam int CELL_SHIFT  = 3;
  localparam int PIX_LIMIT_X = 512;
  localparam int PIX_LIMIT_Y = 480;
  typedef enum logic [1:0] {WALL, START, END, ERASE} brush_e;
  typedef enum logic [2:0] {IDLE, PAINT, ERASE_OLD, PLACE, CLEAR} state_e;
  typedef struct packed {
    logic [5:0] cx;
    logic [5:0] cy;
  } cell_t;
endpackage

// File: rtl/paint_brush_ctrl_if.sv
// paint_brush_ctrl_if: mouse/brush inputs and render-stage paint port
interface paint_brush_ctrl_if;
  logic       Run;
  logic [9:0] MouseX;
  logic [9:0] MouseY;
  logic       BtnLeft;
  logic       BtnRight;
  logic [1:0] BrushSel;
  logic       ClearReq;
  logic       WE;
  logic [9:0] WriteX;
  logic [9:0] WriteY;
  logic [7:0] WritePixel;
  logic       Busy;
  modport master (
    output Run, MouseX, MouseY, BtnLeft, BtnRight, BrushSel, ClearReq,
    input  WE, WriteX, WriteY, WritePixel, Busy
  );
  modport slave (
    input  Run, MouseX, MouseY, BtnLeft, BtnRight, BrushSel, ClearReq,
    output WE, WriteX, WriteY, WritePixel, Busy
  );
endinterface

// File: rtl/grid_sweep_cnt.sv
// grid_sweep_cnt: row-major cell walker over the 64x60 grid
module grid_sweep_cnt
  import paint_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       advance,
  output logic [5:0] cx,
  output logic [5:0] cy,
  output logic       last
);
  assign last = cx == 6'(GRID_W - 1) && cy == 6'(GRID_H - 1);
  // start claims the origin; if it is consumed in the same cycle the walk resumes at cell 1
  always_ff @(posedge Clk)
    if (Reset) begin
      cx <= '0;
      cy <= '0;
    end else if (start) begin
      cx <= {5'b0, advance};
      cy <= '0;
    end else if (advance) begin
      cx <= cx == 6'(GRID_W - 1) ? '0 : cx + 6'd1;
      cy <= cx != 6'(GRID_W - 1) ? cy : last ? '0 : cy + 6'd1;
    end
endmodule

// File: rtl/paint_brush_ctrl.sv
// paint_brush_ctrl: turns mouse samples and brush selection into single-cell paint writes
module paint_brush_ctrl
  import paint_pkg::*;
#(
  parameter logic [7:0] WALL_COLOR  = 8'd3,
  parameter logic [7:0] START_COLOR = 8'd1,
  parameter logic [7:0] END_COLOR   = 8'd2,
  parameter logic [7:0] ERASE_COLOR = 8'd0
) (
  input logic               Clk,
  input logic               Reset,
  paint_brush_ctrl_if.slave bus
);
  state_e     state, state_n;
  brush_e     brush, lat_brush;
  cell_t      cur, lat, old, start_c, end_c, last_c;
  logic       start_v, end_v, last_v, prev_press;
  logic [7:0] col, last_col, pix_n;
  logic       cell_ok, press, trig, clear_go, commit, place_old;
  logic       sweep_start, sweep_last, sweep_done;
  logic [5:0] sx, sy;
  logic       we_n, busy_n;
  logic [9:0] x_n, y_n;

  function automatic logic [7:0] color_of(brush_e b);
    return b == WALL ? WALL_COLOR : b == START ? START_COLOR : b == END ? END_COLOR : ERASE_COLOR;
  endfunction

  function automatic logic [9:0] pix(logic [5:0] c);
    return {1'b0, c, 3'b000};
  endfunction

  assign cur        = {bus.MouseX[CELL_SHIFT +: 6], bus.MouseY[CELL_SHIFT +: 6]};
  assign cell_ok    = bus.MouseX < 10'(PIX_LIMIT_X) && bus.MouseY < 10'(PIX_LIMIT_Y);
  assign press      = bus.BtnLeft | bus.BtnRight;
  assign brush      = bus.BtnRight ? ERASE : brush_e'(bus.BrushSel);
  assign col        = color_of(brush);
  assign clear_go   = bus.ClearReq && state != CLEAR;
  assign commit     = !bus.Run && !bus.ClearReq;
  assign sweep_done = state == CLEAR && !bus.Run && sweep_last;
  assign trig       = state == IDLE && commit && cell_ok && press &&
                      (!last_v || !prev_press || cur != last_c || col != last_col);
  assign place_old  = brush == START ? start_v && start_c != cur : end_v && end_c != cur;

  grid_sweep_cnt u_sweep (
    .Clk     (Clk),
    .Reset   (Reset),
    .start   (sweep_start),
    .advance (!bus.Run),
    .cx      (sx),
    .cy      (sy),
    .last    (sweep_last)
  );

  // Next state and next paint-port value; idle shows the cursor in the brush colour
  always_comb begin
    state_n     = state;
    sweep_start = 1'b0;
    we_n        = 1'b0;
    busy_n      = 1'b0;
    x_n         = bus.MouseX;
    y_n         = bus.MouseY;
    pix_n       = color_of(brush_e'(bus.BrushSel));
    if (clear_go) begin
      state_n     = CLEAR;
      sweep_start = 1'b1;
      busy_n      = 1'b1;
      we_n        = !bus.Run;
      x_n         = '0;
      y_n         = '0;
      pix_n       = ERASE_COLOR;
    end else if (state == CLEAR) begin
      busy_n = 1'b1;
      if (!bus.Run) begin
        we_n    = 1'b1;
        x_n     = pix(sx);
        y_n     = pix(sy);
        pix_n   = ERASE_COLOR;
        state_n = sweep_last ? IDLE : CLEAR;
      end
    end else if (trig)
      state_n = brush inside {WALL, ERASE} ? PAINT : place_old ? ERASE_OLD : PLACE;
    else if (state != IDLE && !bus.Run) begin
      we_n    = 1'b1;
      x_n     = pix(state == ERASE_OLD ? old.cx : lat.cx);
      y_n     = pix(state == ERASE_OLD ? old.cy : lat.cy);
      pix_n   = state == ERASE_OLD ? ERASE_COLOR : color_of(lat_brush);
      state_n = state == ERASE_OLD ? PLACE : IDLE;
    end
  end

  // State register and registered paint port
  always_ff @(posedge Clk)
    if (Reset) begin
      state          <= IDLE;
      prev_press     <= 1'b0;
      bus.WE         <= 1'b0;
      bus.WriteX     <= '0;
      bus.WriteY     <= '0;
      bus.WritePixel <= ERASE_COLOR;
      bus.Busy       <= 1'b0;
    end else begin
      state          <= state_n;
      prev_press     <= press;
      bus.WE         <= we_n;
      bus.WriteX     <= x_n;
      bus.WriteY     <= y_n;
      bus.WritePixel <= pix_n;
      bus.Busy       <= busy_n;
    end

  // Target cell and brush are frozen at the trigger so mouse motion cannot disturb a placement
  always_ff @(posedge Clk)
    if (trig) begin
      lat       <= cur;
      lat_brush <= brush;
      old       <= brush == START ? start_c : end_c;
    end

  // Start/end/last-write tracking; any write landing on a tracked cell retires that tracking
  always_ff @(posedge Clk)
    if (Reset || sweep_done) begin
      start_v <= 1'b0;
      end_v   <= 1'b0;
      last_v  <= 1'b0;
    end else begin
      if (trig) begin
        last_v   <= 1'b1;
        last_c   <= cur;
        last_col <= col;
      end
      if (commit && state == PAINT) begin
        if (start_c == lat) start_v <= 1'b0;
        if (end_c == lat) end_v <= 1'b0;
      end
      if (commit && state == PLACE) begin
        if (lat_brush == START) begin
          start_v <= 1'b1;
          start_c <= lat;
          if (end_c == lat) end_v <= 1'b0;
        end else begin
          end_v <= 1'b1;
          end_c <= lat;
          if (start_c == lat) start_v <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_paint_brush_ctrl.sv
// tb_paint_brush_ctrl: directed stimulus checked against a cell-level write model
module tb_paint_brush_ctrl;
  typedef struct {
    int x;
    int y;
    int p;
    int c;
  } wr_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int nchk = 0, nfail = 0, cyc = 0, busy_cnt = 0;
  wr_t exp_q[$];
  wr_t obs[$];
  int colr[4] = '{3, 1, 2, 0};
  bit st_v = 0, en_v = 0;
  int st_x, st_y, en_x, en_y;

  paint_brush_ctrl_if bus ();

  paint_brush_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(int x, int y, int p);
    exp_q.push_back('{x, y, p, 0});
  endtask

  // Model: what a fresh press at pixel (x,y) must write
  task automatic model_hit(int x, int y, int sel, bit l, bit r);
    int cx = x / 8;
    int cy = y / 8;
    int b = r ? 3 : sel;
    if (x >= 512 || y >= 480 || !(l || r)) return;
    if (b == 0 || b == 3) begin
      push(cx * 8, cy * 8, colr[b]);
      if (st_v && st_x == cx && st_y == cy) st_v = 0;
      if (en_v && en_x == cx && en_y == cy) en_v = 0;
    end else if (b == 1) begin
      if (st_v && !(st_x == cx && st_y == cy)) push(st_x * 8, st_y * 8, 0);
      push(cx * 8, cy * 8, 1);
      st_v = 1; st_x = cx; st_y = cy;
      if (en_v && en_x == cx && en_y == cy) en_v = 0;
    end else begin
      if (en_v && !(en_x == cx && en_y == cy)) push(en_x * 8, en_y * 8, 0);
      push(cx * 8, cy * 8, 2);
      en_v = 1; en_x = cx; en_y = cy;
      if (st_v && st_x == cx && st_y == cy) st_v = 0;
    end
  endtask

  task automatic clear_model();
    for (int y = 0; y < 60; y++)
      for (int x = 0; x < 64; x++) push(x * 8, y * 8, 0);
    st_v = 0;
    en_v = 0;
  endtask

  task automatic click(int x, int y, int sel, bit l, bit r, int hold);
    model_hit(x, y, sel, l, r);
    bus.MouseX = 10'(x);
    bus.MouseY = 10'(y);
    bus.BrushSel = 2'(sel);
    bus.BtnLeft = l;
    bus.BtnRight = r;
    repeat (hold) @(negedge Clk);
    bus.BtnLeft = 0;
    bus.BtnRight = 0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic do_clear(int pause_at, int pause_len, int dup_at, int exp_busy);
    int n = 0;
    int b0 = busy_cnt;
    int base = obs.size();
    clear_model();
    bus.ClearReq = 1;
    @(negedge Clk);
    bus.ClearReq = 0;
    while (bus.Busy === 1'b1 && n < 5000) begin
      n++;
      bus.Run = n >= pause_at && n < pause_at + pause_len;
      bus.ClearReq = n == dup_at;
      @(negedge Clk);
    end
    bus.Run = 0;
    bus.ClearReq = 0;
    chk("clear_terminates", 32'(n < 5000), 1);
    chk("busy_cycles", busy_cnt - b0, exp_busy);
    chk("sweep_writes", obs.size() - base, 3840);
    chk("sweep_first_x", obs[base].x, 0);
    chk("sweep_first_y", obs[base].y, 0);
    chk("sweep_65_x", obs[base + 64].x, 0);
    chk("sweep_65_y", obs[base + 64].y, 8);
    chk("sweep_last_x", obs[base + 3839].x, 504);
    chk("sweep_last_y", obs[base + 3839].y, 472);
    chk("sweep_last_p", obs[base + 3839].p, 0);
  endtask

  always @(posedge Clk) cyc++;

  // Every write on the paint port must be the next one the model predicts
  always @(posedge Clk) begin : cmp
    wr_t e;
    #1;
    if (bus.Busy === 1'b1) busy_cnt++;
    if (bus.WE === 1'b1) begin
      obs.push_back('{int'(bus.WriteX), int'(bus.WriteY), int'(bus.WritePixel), cyc});
      chk("we_while_run", 32'(bus.Run), 0);
      if (exp_q.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL spurious_write: got x=%0d y=%0d p=%0d expected no write", bus.WriteX, bus.WriteY, bus.WritePixel);
      end else begin
        e = exp_q.pop_front();
        chk("wr_x", 32'(bus.WriteX), e.x);
        chk("wr_y", 32'(bus.WriteY), e.y);
        chk("wr_p", 32'(bus.WritePixel), e.p);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, t;
    int dx[4] = '{0, 3, 8, 16};
    int prev;
    bus.Run = 0; bus.MouseX = 0; bus.MouseY = 0; bus.BtnLeft = 0;
    bus.BtnRight = 0; bus.BrushSel = 0; bus.ClearReq = 0;
    repeat (3) @(negedge Clk);
    chk("rst_we", 32'(bus.WE), 0);
    chk("rst_x", 32'(bus.WriteX), 0);
    chk("rst_y", 32'(bus.WriteY), 0);
    chk("rst_pix", 32'(bus.WritePixel), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    Reset = 0;
    bus.MouseX = 123; bus.MouseY = 77; bus.BrushSel = 2;
    repeat (2) @(negedge Clk);
    chk("cursor_x", 32'(bus.WriteX), 123);
    chk("cursor_y", 32'(bus.WriteY), 77);
    chk("cursor_pix", 32'(bus.WritePixel), 2);
    n0 = obs.size();
    click(100, 50, 0, 1, 0, 5);
    chk("wall_count", obs.size() - n0, 1);
    chk("wall_x", obs[n0].x, 96);
    chk("wall_y", obs[n0].y, 48);
    chk("wall_p", obs[n0].p, 3);
    click(16, 16, 1, 1, 0, 1);
    n0 = obs.size();
    click(200, 8, 1, 1, 0, 1);
    chk("move_count", obs.size() - n0, 2);
    chk("move_old_x", obs[n0].x, 16);
    chk("move_old_y", obs[n0].y, 16);
    chk("move_old_p", obs[n0].p, 0);
    chk("move_new_x", obs[n0 + 1].x, 200);
    chk("move_new_y", obs[n0 + 1].y, 8);
    chk("move_new_p", obs[n0 + 1].p, 1);
    chk("move_adjacent", obs[n0 + 1].c - obs[n0].c, 1);
    n0 = obs.size();
    model_hit(300, 300, 0, 1, 0);
    bus.MouseX = 300; bus.MouseY = 300; bus.BrushSel = 0; bus.BtnLeft = 1;
    @(negedge Clk);
    bus.Run = 1; bus.BtnLeft = 0; bus.MouseX = 8; bus.MouseY = 400;
    repeat (10) @(negedge Clk);
    chk("stall_no_write", obs.size() - n0, 0);
    bus.Run = 0;
    t = cyc;
    repeat (4) @(negedge Clk);
    chk("stall_count", obs.size() - n0, 1);
    chk("stall_cycle", obs[n0].c, t + 1);
    chk("stall_x", obs[n0].x, 296);
    chk("stall_y", obs[n0].y, 296);
    do_clear(0, 0, 0, 3840);
    do_clear(100, 20, 1000, 3860);
    n0 = obs.size();
    click(16, 16, 1, 1, 0, 1);
    chk("post_clear_place", obs.size() - n0, 1);
    chk("post_clear_p", obs[n0].p, 1);
    n0 = obs.size();
    click(600, 50, 0, 1, 0, 3);
    chk("offgrid_none", obs.size() - n0, 0);
    n0 = obs.size();
    click(8, 8, 0, 1, 1, 2);
    chk("both_count", obs.size() - n0, 1);
    chk("both_p", obs[n0].p, 0);
    click(64, 64, 2, 1, 0, 1);
    click(64, 64, 1, 1, 0, 1);
    n0 = obs.size();
    click(80, 80, 2, 1, 0, 1);
    chk("end_retired", obs.size() - n0, 1);
    bus.BrushSel = 0; bus.BtnLeft = 1;
    prev = -1;
    foreach (dx[i]) begin
      if (dx[i] / 8 != prev) model_hit(dx[i], 400, 0, 1, 0);
      prev = dx[i] / 8;
      bus.MouseX = 10'(dx[i]); bus.MouseY = 400;
      repeat (3) @(negedge Clk);
    end
    bus.BtnLeft = 0;
    repeat (3) @(negedge Clk);
    click(64, 64, 0, 1, 0, 1);
    n0 = obs.size();
    click(96, 96, 1, 1, 0, 1);
    chk("start_overwritten", obs.size() - n0, 1);
    clear_model();
    bus.ClearReq = 1;
    @(negedge Clk);
    bus.ClearReq = 0;
    repeat (99) @(negedge Clk);
    Reset = 1;
    @(posedge Clk);
    #1;
    chk("rst_sweep_we", 32'(bus.WE), 0);
    chk("rst_sweep_busy", 32'(bus.Busy), 0);
    exp_q.delete();
    st_v = 0; en_v = 0;
    @(negedge Clk);
    Reset = 0;
    n0 = obs.size();
    click(24, 24, 1, 1, 0, 1);
    chk("rst_place_only", obs.size() - n0, 1);
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
    st_v = 0; en_v = 0;
    n0 = obs.size();
    click(32, 32, 1, 1, 0, 1);
    chk("idle_rst_place_only", obs.size() - n0, 1);
    chk("drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
